// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Round-robin arbiter and sequencer that shares one single-port memory
//   among NUM_REQ requesters. One access is in flight at a time. The
//   memory strobes are driven for exactly one cycle per access, and read
//   data is returned to the requester that won the grant.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   req          per-requester request (level, held until granted)
//   req_we       per-requester direction: 1 = write, 0 = read
//   req_addr     flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata    flattened write data, requester i at [i*DATA_W +: DATA_W]
//   gnt          one-hot, one-cycle pulse: request accepted
//   rd_valid     one-hot, one-cycle pulse: rd_data valid for that requester
//   rd_data      read data shared by all requesters, held until next read
//   busy         high whenever the sequencer is not idle
//   mem_addr     memory address
//   mem_wr_en    memory write strobe
//   mem_rd_en    memory read strobe
//   mem_wr_data  memory write data
//   mem_rd_data  memory read data, valid the cycle after the read strobe
//
// State  | meaning
// -------+-----------------------------------------------------------
// IDLE   | sampling req; the round-robin winner is granted here
// ACCESS | strobe is on the memory pins; memory samples it at this edge
// RDWAIT | read data is on mem_rd_data; capture it and pulse rd_valid

module mem_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      busy,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_wr_en,
  output logic                      mem_rd_en,
  output logic [DATA_W-1:0]         mem_wr_data,
  input  logic [DATA_W-1:0]         mem_rd_data
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_wr_en_q, mem_wr_en_d;
  logic                mem_rd_en_q, mem_rd_en_d;
  logic [DATA_W-1:0]   mem_wr_data_q, mem_wr_data_d;

  logic                win_found;
  logic [ID_W-1:0]     win_id;
  logic [ID_W-1:0]     rr_next;

  // Winner search: first set req bit starting at rr_ptr, wrapping modulo
  // NUM_REQ. The index is wrapped explicitly so non-power-of-two NUM_REQ
  // never points past the last requester.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && req[ID_W'(idx)]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  assign rr_next = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    id_d          = id_q;
    gnt_d         = '0;
    rd_valid_d    = '0;
    rd_data_d     = rd_data_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_wr_en_d   = 1'b0;
    mem_rd_en_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          id_d          = win_id;
          gnt_d[win_id] = 1'b1;
          mem_addr_d    = req_addr[int'(win_id)*ADDR_W +: ADDR_W];
          mem_wr_data_d = req_wdata[int'(win_id)*DATA_W +: DATA_W];
          mem_wr_en_d   = req_we[win_id];
          mem_rd_en_d   = !req_we[win_id];
          rr_ptr_d      = rr_next;
          state_d       = ACCESS;
        end
      end
      // The registered read strobe remembers the direction of the access.
      ACCESS: state_d = mem_rd_en_q ? RDWAIT : IDLE;
      RDWAIT: begin
        rd_data_d        = mem_rd_data;
        rd_valid_d[id_q] = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      id_q          <= '0;
      gnt_q         <= '0;
      rd_valid_q    <= '0;
      rd_data_q     <= '0;
      busy_q        <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_wr_data_q <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      id_q          <= id_d;
      gnt_q         <= gnt_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
      busy_q        <= busy_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_wr_data_q <= mem_wr_data_d;
    end
  end

  assign gnt         = gnt_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign busy        = busy_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_wr_data = mem_wr_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Drives two arbiters (NUM_REQ=2 and NUM_REQ=4) that share clk/rst, each
//   in front of its own 4x8 memory model. Expected outputs come from a
//   transaction-level model: the arbiter is free again a fixed number of
//   edges after each grant, and read data is due two edges after the grant.

module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // instance A: NUM_REQ = 2
  logic [1:0]  req_a, we_a;
  logic [3:0]  addr_a;
  logic [15:0] wdata_a;
  logic [1:0]  gnt_a, rv_a;
  logic [7:0]  rdd_a;
  logic        busy_a;
  logic [1:0]  maddr_a;
  logic        mwe_a, mre_a;
  logic [7:0]  mwd_a;
  logic [7:0]  mrd_a = 8'h00;
  logic [7:0]  mem_a [4] = '{default: 8'h00};

  // instance B: NUM_REQ = 4
  logic [3:0]  req_b, we_b;
  logic [7:0]  addr_b;
  logic [31:0] wdata_b;
  logic [3:0]  gnt_b, rv_b;
  logic [7:0]  rdd_b;
  logic        busy_b;
  logic [1:0]  maddr_b;
  logic        mwe_b, mre_b;
  logic [7:0]  mwd_b;
  logic [7:0]  mrd_b = 8'h00;
  logic [7:0]  mem_b [4] = '{default: 8'h00};

  mem_arbiter u_a (
    .clk(clk), .rst(rst), .req(req_a), .req_we(we_a), .req_addr(addr_a),
    .req_wdata(wdata_a), .gnt(gnt_a), .rd_valid(rv_a), .rd_data(rdd_a),
    .busy(busy_a), .mem_addr(maddr_a), .mem_wr_en(mwe_a), .mem_rd_en(mre_a),
    .mem_wr_data(mwd_a), .mem_rd_data(mrd_a)
  );

  mem_arbiter #(.NUM_REQ(4)) u_b (
    .clk(clk), .rst(rst), .req(req_b), .req_we(we_b), .req_addr(addr_b),
    .req_wdata(wdata_b), .gnt(gnt_b), .rd_valid(rv_b), .rd_data(rdd_b),
    .busy(busy_b), .mem_addr(maddr_b), .mem_wr_en(mwe_b), .mem_rd_en(mre_b),
    .mem_wr_data(mwd_b), .mem_rd_data(mrd_b)
  );

  always @(posedge clk) begin
    if (mwe_a) mem_a[maddr_a] <= mwd_a;
    if (mre_a) mrd_a <= mem_a[maddr_a];
    if (mwe_b) mem_b[maddr_b] <= mwd_b;
    if (mre_b) mrd_b <= mem_b[maddr_b];
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // reference model state, index 0 = A, 1 = B
  int         free_at[2], rr_m[2], rd_due[2], rd_id[2];
  logic [7:0] rd_val_m[2];
  logic [7:0] mem_m[2][4];
  logic [7:0] e_gnt[2], e_rv[2], e_rdd[2], e_addr[2], e_wd[2];
  logic       e_busy[2], e_we[2], e_re[2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_reset(input int u);
    free_at[u] = 0;
    rr_m[u]    = 0;
    rd_due[u]  = -1;
    rd_id[u]   = 0;
    rd_val_m[u] = 8'h00;
    e_gnt[u] = 8'h00; e_rv[u] = 8'h00; e_rdd[u] = 8'h00;
    e_addr[u] = 8'h00; e_wd[u] = 8'h00;
    e_busy[u] = 1'b0; e_we[u] = 1'b0; e_re[u] = 1'b0;
  endtask

  // Outputs expected right after edge number cyc, given the inputs sampled there.
  task automatic model_edge(input int u, input int n, input logic [7:0] rq,
                            input logic [7:0] we, input logic [15:0] ad,
                            input logic [63:0] wd);
    int w;
    logic [1:0] a;
    w = -1;
    e_gnt[u] = 8'h00; e_rv[u] = 8'h00; e_we[u] = 1'b0; e_re[u] = 1'b0;
    if (rd_due[u] == cyc) begin
      e_rv[u]  = 8'(1) << rd_id[u];
      e_rdd[u] = rd_val_m[u];
      rd_due[u] = -1;
    end
    if (cyc >= free_at[u] && rq != 8'h00) begin
      for (int k = 0; k < n; k++) begin
        int c;
        c = (rr_m[u] + k) % n;
        if (w < 0 && rq[c]) w = c;
      end
      a         = ad[w*2 +: 2];
      e_gnt[u]  = 8'(1) << w;
      e_addr[u] = 8'(a);
      e_wd[u]   = wd[w*8 +: 8];
      rr_m[u]   = (w + 1) % n;
      if (we[w]) begin
        e_we[u]     = 1'b1;
        mem_m[u][a] = wd[w*8 +: 8];
        free_at[u]  = cyc + 2;
      end else begin
        e_re[u]     = 1'b1;
        rd_val_m[u] = mem_m[u][a];
        rd_id[u]    = w;
        rd_due[u]   = cyc + 2;
        free_at[u]  = cyc + 3;
      end
    end
    e_busy[u] = (cyc <= free_at[u] - 2);
  endtask

  task automatic check_all();
    chk("a_gnt",  64'(gnt_a),  64'(e_gnt[0]));
    chk("a_rv",   64'(rv_a),   64'(e_rv[0]));
    chk("a_rdd",  64'(rdd_a),  64'(e_rdd[0]));
    chk("a_busy", 64'(busy_a), 64'(e_busy[0]));
    chk("a_we",   64'(mwe_a),  64'(e_we[0]));
    chk("a_re",   64'(mre_a),  64'(e_re[0]));
    if (e_we[0] || e_re[0]) begin
      chk("a_addr", 64'(maddr_a), 64'(e_addr[0]));
      chk("a_wd",   64'(mwd_a),   64'(e_wd[0]));
    end
    chk("b_gnt",  64'(gnt_b),  64'(e_gnt[1]));
    chk("b_rv",   64'(rv_b),   64'(e_rv[1]));
    chk("b_rdd",  64'(rdd_b),  64'(e_rdd[1]));
    chk("b_busy", 64'(busy_b), 64'(e_busy[1]));
    chk("b_we",   64'(mwe_b),  64'(e_we[1]));
    chk("b_re",   64'(mre_b),  64'(e_re[1]));
    if (e_we[1] || e_re[1]) begin
      chk("b_addr", 64'(maddr_b), 64'(e_addr[1]));
      chk("b_wd",   64'(mwd_b),   64'(e_wd[1]));
    end
  endtask

  // One clock: model the edge, check just after it, return at the negedge.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      model_edge(0, 2, 8'(req_a), 8'(we_a), 16'(addr_a), 64'(wdata_a));
      model_edge(1, 4, 8'(req_b), 8'(we_b), 16'(addr_b), 64'(wdata_b));
    end
    #1;
    check_all();
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int order[7] = '{0, 1, 2, 3, 0, 1, 3};
    logic [3:0] eb;

    rst = 1'b0;
    req_a = '0; we_a = '0; addr_a = '0; wdata_a = '0;
    req_b = '0; we_b = '0; addr_b = '0; wdata_b = '0;
    for (int u = 0; u < 2; u++) begin
      model_reset(u);
      for (int i = 0; i < 4; i++) mem_m[u][i] = 8'h00;
    end
    #2;
    check_all();
    @(negedge clk);
    rst = 1'b1;

    // single write by requester 0
    req_a = 2'b01; we_a = 2'b01; addr_a[1:0] = 2'd2; wdata_a[7:0] = 8'hA5;
    step();
    chk("t1_gnt",  64'(gnt_a), 64'(2'b01));
    chk("t1_busy", 64'(busy_a), 64'(1'b1));
    req_a = 2'b00;
    step();
    chk("t1_idle", 64'(busy_a), 64'(1'b0));
    step();

    // read back by requester 1
    req_a = 2'b10; we_a = 2'b00; addr_a[3:2] = 2'd2;
    step();
    chk("t2_gnt", 64'(gnt_a), 64'(2'b10));
    req_a = 2'b00;
    step();
    step();
    chk("t2_rv",  64'(rv_a),  64'(2'b10));
    chk("t2_rdd", 64'(rdd_a), 64'(8'hA5));

    // both requesters writing continuously
    req_a = 2'b11; we_a = 2'b11; addr_a = {2'd3, 2'd1}; wdata_a = 16'h5A3C;
    repeat (8) step();
    req_a = 2'b00;
    repeat (2) step();

    // requester 0: four writes, then four reads with payload changed per access
    req_a = 2'b01; we_a = 2'b01;
    for (int i = 0; i < 4; i++) begin
      addr_a[1:0] = 2'(i); wdata_a[7:0] = 8'(8'h11 * (i + 1));
      step(); step();
    end
    we_a = 2'b00;
    for (int i = 0; i < 4; i++) begin
      addr_a[1:0] = 2'(i);
      step(); step(); step();
      chk("t4_rv",  64'(rv_a),  64'(2'b01));
      chk("t4_rdd", 64'(rdd_a), 64'(8'(8'h11 * (i + 1))));
    end
    req_a = 2'b00;
    step();

    // reset while a read is waiting for data
    req_a = 2'b01; we_a = 2'b00; addr_a[1:0] = 2'd1;
    step();
    req_a = 2'b00;
    step();
    rst = 1'b0;
    #1;
    model_reset(0); model_reset(1);
    check_all();
    step();
    rst = 1'b1;
    req_a = 2'b11; we_a = 2'b11; addr_a = 4'b0100; wdata_a = 16'hBEEF;
    step();
    chk("t5_rr", 64'(gnt_a), 64'(2'b01));
    req_a = 2'b00;
    repeat (2) step();

    // four requesters, requester 2 drops out after its grant
    req_b = 4'hF; we_b = 4'hF; addr_b = {2'd3, 2'd2, 2'd1, 2'd0}; wdata_b = 32'h44332211;
    for (int s = 0; s <= 12; s++) begin
      step();
      if (s % 2 == 0) begin
        eb = 4'b0001 << order[s / 2];
        chk("b_order", 64'(gnt_b), 64'(eb));
      end
      if (s == 4) req_b[2] = 1'b0;
    end
    req_b = 4'h0;
    repeat (2) step();

    // random traffic on both instances
    repeat (3000) begin
      req_a   = 2'($urandom_range(0, 3));
      we_a    = 2'($urandom);
      addr_a  = 4'($urandom);
      wdata_a = 16'($urandom);
      req_b   = 4'($urandom);
      we_b    = 4'($urandom);
      addr_b  = 8'($urandom);
      wdata_b = $urandom;
      step();
    end
    req_a = '0; req_b = '0;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one single-port 4x8 memory among NUM_REQ requesters.
- Accepts one request at a time and drives the memory's addr/wr_en/rd_en/wr_data pins for exactly one cycle per access.
- Returns read data to the winning requester.
- Sits between requester agents/blocks and the memory port, on the same clk.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 2, memory address width.
- DATA_W, 8, memory data width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset. This is the already-decided reset: one clock, reset asynchronous and active-low, port names clk and rst.
- req  input  NUM_REQ  per-requester request.
- req_we  input  NUM_REQ  per-requester: 1 = write, 0 = read.
- req_addr  input  NUM_REQ*ADDR_W  flattened addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  input  NUM_REQ*DATA_W  flattened write data; same packing as req_addr.
- gnt  output  NUM_REQ  one-hot, 1-cycle pulse: request accepted.
- rd_valid  output  NUM_REQ  one-hot, 1-cycle pulse: rd_data valid for that requester.
- rd_data  output  DATA_W  read data, shared by all requesters.
- busy  output  1  high whenever state != IDLE.
- mem_addr  output  ADDR_W  memory address.
- mem_wr_en  output  1  memory write strobe.
- mem_rd_en  output  1  memory read strobe.
- mem_wr_data  output  DATA_W  memory write data.
- mem_rd_data  input  DATA_W  memory read data. Valid the cycle after the edge at which the memory samples mem_rd_en=1.

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: gnt=0, rd_valid=0, rd_data=0, busy=0, mem_addr=0, mem_wr_en=0, mem_rd_en=0, mem_wr_data=0.
  - Internal: state=IDLE, rr_ptr=0.
- All outputs are registered.
- FSM states: IDLE, ACCESS, RDWAIT.
- IDLE:
  - At each edge with any req bit set, select the winner: the first set bit searching rr_ptr, rr_ptr+1, ... wrapping modulo NUM_REQ.
  - Latch the winner's id, req_we, addr and wdata.
  - Set gnt[id]=1 and drive mem_addr/mem_wr_data from the latched values.
  - Set mem_wr_en=req_we or mem_rd_en=!req_we.
  - Set rr_ptr = (id+1) mod NUM_REQ, then go to ACCESS.
  - If no req bit is set, stay in IDLE with all strobes 0.
- ACCESS:
  - Memory samples the strobe at this edge.
  - Clear gnt, mem_wr_en and mem_rd_en.
  - Write: go to IDLE. Read: go to RDWAIT.
- RDWAIT:
  - Capture mem_rd_data into rd_data, pulse rd_valid[id]=1 for one cycle, go to IDLE.
  - rd_data holds its value until the next read completes.
- Latency from the req-sampling edge:
  - gnt and strobe: +1 cycle.
  - Read rd_valid: +3 cycles, counted as edges (edge0 grant, edge1 memory access, edge2 capture).
- Throughput:
  - Write: 1 per 2 cycles.
  - Read: 1 per 3 cycles.
  - Requests are not sampled in ACCESS or RDWAIT.
- Handshake:
  - Payload is latched at the grant edge.
  - The requester may change req/payload during the gnt-high cycle.
  - A req left high is treated as a new request at the next IDLE sample.
  - No request is dropped: req is level-sensitive and waits until granted.
- Fairness: with all NUM_REQ requesting continuously, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 grants.
- Simultaneous events:
  - Multiple req bits in IDLE: only the round-robin winner is granted; the others wait.
  - req deasserting during ACCESS/RDWAIT does not affect the in-flight access.
- Reset mid-operation: an in-flight access is abandoned. No rd_valid is issued for it, strobes go to 0 immediately, and rr_ptr returns to 0.
- Address/data are passed through unmodified; no arithmetic on data. rr_ptr wraps modulo NUM_REQ.
- gnt and rd_valid are never high in the same cycle as each other for different ids.
- mem_wr_en and mem_rd_en are never both high.

Test Plan:
- Reset release, then req[0]=1, we=1, addr=2, wdata=8'hA5 → next cycle gnt=2'b01, mem_wr_en=1, mem_addr=2, mem_wr_data=8'hA5 for exactly one cycle; busy high one cycle.
- After the write above, req[1]=1, we=0, addr=2 → gnt=2'b10, mem_rd_en=1 one cycle; two cycles later rd_valid=2'b10, rd_data=8'hA5.
- req=2'b11 held continuously, both writing → gnt sequence 01,10,01,10 on every other cycle; mem_addr alternates between the requesters' addresses.
- Only req[0] held high with 4 reads to addrs 0..3 (payload updated in each gnt cycle) → a grant every 3 cycles, rd_valid[0] four times, data matches prior writes 8'h11,8'h22,8'h33,8'h44.
- Read granted, rst pulsed low during RDWAIT → all outputs 0 immediately, no rd_valid; after release with req=2'b11, the first grant goes to requester 0 (rr_ptr reset).
- NUM_REQ=4, req=4'b1111 held continuously → grant order 0,1,2,3,0; drop req[2] mid-sequence → order continues 3,0,1,3.
